// File: rtl/uart_tx_arbiter_if.sv
// Source-side write ports and UART transmitter handshake for uart_tx_arbiter.
// slave = arbiter side, master = sources/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [2:0]    src_wr;
  logic [23:0]   src_din;
  logic [2:0]    src_ready;
  logic          uart_wr;
  logic [7:0]    uart_din;
  logic          uart_ready;
  logic [LW-1:0] level;
  logic          busy;

  modport slave (
    input  src_wr, src_din, uart_ready,
    output src_ready, uart_wr, uart_din, level, busy
  );

  modport master (
    output src_wr, src_din, uart_ready,
    input  src_ready, uart_wr, uart_din, level, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Three-source round-robin byte arbiter feeding a FIFO that drains into a UART
// transmitter through a strobe / wait-for-busy / wait-for-idle handshake.
module uart_tx_arbiter #(
  parameter int DEPTH        = 16,
  parameter int WAIT_LOW_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_LOW_MAX < 2) ? 1 : $clog2(WAIT_LOW_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

  // Reset asserts asynchronously, releases two edges after reset falls.
  logic [1:0] rst_q;
  logic       rst_s;
  always_ff @(posedge clk or posedge reset)
    if (reset) rst_q <= 2'b11;
    else       rst_q <= {rst_q[0], 1'b0};
  assign rst_s = rst_q[1];

  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wptr, rptr;
  logic [AW:0]           lvl;
  logic [1:0]            rr_ptr, gnt_idx, k;
  logic [2:0]            gnt;
  logic [2:0][7:0]       src_b;
  logic                  push, pop;
  state_t                state, state_n;
  logic [CW-1:0]         wcnt;
  logic                  uart_wr_q;
  logic [7:0]            uart_din_q;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign src_b = bus.src_din;

  // Round-robin search starts one past the last accepted source.
  always_comb begin
    gnt     = '0;
    gnt_idx = rr_ptr;
    k       = nxt(rr_ptr);
    if (!rst_s && (lvl < (AW+1)'(DEPTH))) begin
      for (int i = 0; i < 3; i++) begin
        if (gnt == '0 && bus.src_wr[k]) begin
          gnt[k]  = 1'b1;
          gnt_idx = k;
        end
        k = nxt(k);
      end
    end
  end

  assign push = |gnt;

  always_ff @(posedge clk)
    if (push) mem[wptr] <= src_b[gnt_idx];

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      wptr   <= '0;
      rptr   <= '0;
      lvl    <= '0;
      rr_ptr <= 2'd2;
    end else begin
      if (push) begin
        wptr   <= wptr + AW'(1);
        rr_ptr <= gnt_idx;
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   lvl <= lvl + (AW+1)'(1);
        2'b01:   lvl <= lvl - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE:      if (lvl != '0 && bus.uart_ready) begin
                   state_n = ISSUE;
                   pop     = 1'b1;
                 end
      ISSUE:     state_n = WAIT_LOW;
      // Bounded wait: a transmitter that never drops ready must not stall us.
      WAIT_LOW:  if (!bus.uart_ready || wcnt == CW'(WAIT_LOW_MAX - 1)) state_n = WAIT_HIGH;
      WAIT_HIGH: if (bus.uart_ready) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state      <= IDLE;
      wcnt       <= '0;
      uart_wr_q  <= 1'b0;
      uart_din_q <= '0;
    end else begin
      state     <= state_n;
      uart_wr_q <= (state_n == ISSUE);
      wcnt      <= (state == WAIT_LOW) ? wcnt + CW'(1) : '0;
      if (pop) uart_din_q <= mem[rptr];
    end
  end

  assign bus.src_ready = gnt;
  assign bus.uart_wr   = uart_wr_q;
  assign bus.uart_din  = uart_din_q;
  assign bus.level     = lvl;
  assign bus.busy      = (lvl != '0) || (state != IDLE);
endmodule
